// File: rtl/bht_pkg.sv
// Shared types, counter encodings and the saturating-counter helper for the
// BHT update sequencer.
package bht_pkg;

  typedef struct packed {
    int unsigned BHTEntries;
    int unsigned INSTR_PER_FETCH;
    int unsigned VLEN;
  } bht_cfg_t;

  localparam bht_cfg_t BHT_CFG_DEFAULT = '{BHTEntries: 128, INSTR_PER_FETCH: 2, VLEN: 32};
  localparam int unsigned BHT_DEF_IDX_BITS = $clog2(BHT_CFG_DEFAULT.BHTEntries);

  typedef struct packed {
    logic [BHT_DEF_IDX_BITS-1:0] index;
  } bht_meta_t;

  typedef struct packed {
    logic                            valid;
    logic [BHT_CFG_DEFAULT.VLEN-1:0] pc;
    logic                            taken;
    bht_meta_t                       metadata;
  } bht_update_default_t;

  typedef enum logic [1:0] {
    FLUSH,
    IDLE,
    UPD_RD,
    UPD_WR
  } bht_sched_state_e;

  localparam logic [1:0] BHT_SAT_NT  = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT = 2'b01;
  localparam logic [1:0] BHT_SAT_T   = 2'b11;

  function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) res = (ctr == BHT_SAT_T) ? ctr : ctr + 2'd1;
    else       res = (ctr == BHT_SAT_NT) ? ctr : ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO for queued BHT updates; clear has priority over
// push/pop, and a push while full is dropped even if a pop happens.
module bht_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   cnt_q, cnt_d;
  logic                full_q;
  logic                do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // full is registered from the next occupancy so it has no combinational path
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == (PTR_BITS+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bht_update_sched.sv
// Single-port BHT RAM sequencer: flush walk, prediction reads, queued 2-cycle
// counter RMW updates. Define BHT_SCHED_STATS_EN to add upd_drop_cnt_o.
module bht_update_sched
  import bht_pkg::*;
#(
  parameter bht_cfg_t     CVA6Cfg        = BHT_CFG_DEFAULT,
  parameter type          bht_update_t   = bht_update_default_t,
  parameter int unsigned  NR_ENTRIES     = CVA6Cfg.BHTEntries,
  parameter int unsigned  UPD_FIFO_DEPTH = 4,
  localparam int unsigned IPF            = CVA6Cfg.INSTR_PER_FETCH,
  localparam int unsigned NR_ROWS        = NR_ENTRIES / IPF,
  localparam int unsigned ROW_BITS       = $clog2(NR_ROWS),
  localparam int unsigned COL_BITS       = $clog2(IPF)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_bp_i,
  input  logic                debug_mode_i,
  input  logic                pred_req_i,
  input  logic [ROW_BITS-1:0] pred_row_i,
  output logic                pred_gnt_o,
  input  bht_update_t         bht_update_i,
  output logic                upd_full_o,
  output logic                busy_o,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [ROW_BITS-1:0] ram_addr_o,
  output logic [2*IPF-1:0]    ram_wdata_o,
  input  logic [2*IPF-1:0]    ram_rdata_i
`ifdef BHT_SCHED_STATS_EN
  ,
  output logic [15:0]         upd_drop_cnt_o
`endif
);

  localparam int unsigned IDX_BITS = ROW_BITS + COL_BITS;
  localparam int unsigned ENT_BITS = IDX_BITS + 1;

  bht_sched_state_e    state_q, state_d;
  logic [ROW_BITS-1:0] flush_row_q, flush_row_d;
  logic                upd_accept;
  logic                fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [ENT_BITS-1:0] fifo_wdata, fifo_rdata;
  logic                head_taken;
  logic [IDX_BITS-1:0] head_index;
  logic [ROW_BITS-1:0] head_row;
  logic [COL_BITS-1:0] head_col;
  logic [2*IPF-1:0]    rmw_wdata;
  logic                unused_pc;

  assign upd_accept = bht_update_i.valid && !debug_mode_i && (state_q != FLUSH);
  assign fifo_clear = flush_bp_i || (state_q == FLUSH);
  assign fifo_wdata = {bht_update_i.taken, bht_update_i.metadata.index[IDX_BITS-1:0]};
  assign {head_taken, head_index} = fifo_rdata;
  assign head_row   = head_index[IDX_BITS-1:COL_BITS];
  assign head_col   = head_index[COL_BITS-1:0];
  assign unused_pc  = ^bht_update_i.pc;

  bht_upd_fifo #(
    .DEPTH (UPD_FIFO_DEPTH),
    .WIDTH (ENT_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (fifo_clear),
    .push_i  (upd_accept),
    .pop_i   (fifo_pop),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  for (genvar gi = 0; gi < IPF; gi++) begin : g_col
    assign rmw_wdata[2*gi +: 2] = (head_col == COL_BITS'(gi))
                                  ? bht_sat_update(ram_rdata_i[2*gi +: 2], head_taken)
                                  : ram_rdata_i[2*gi +: 2];
  end

  always_comb begin
    state_d     = state_q;
    flush_row_d = flush_row_q;
    fifo_pop    = 1'b0;
    pred_gnt_o  = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (state_q)
      FLUSH: begin
        ram_req_o   = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = flush_row_q;
        ram_wdata_o = {IPF{BHT_WEAK_NT}};
        flush_row_d = flush_row_q + 1'b1;
        if (flush_row_q == ROW_BITS'(NR_ROWS - 1)) begin
          state_d     = IDLE;
          flush_row_d = '0;
        end
      end
      IDLE: begin
        if (pred_req_i) begin
          pred_gnt_o = 1'b1;
          ram_req_o  = 1'b1;
          ram_addr_o = pred_row_i;
        end else if (!fifo_empty) begin
          state_d = UPD_RD;
        end
      end
      UPD_RD: begin
        ram_req_o  = 1'b1;
        ram_addr_o = head_row;
        state_d    = UPD_WR;
      end
      UPD_WR: begin
        // a flush in this cycle abandons the RMW without touching the RAM
        ram_req_o   = !flush_bp_i;
        ram_we_o    = !flush_bp_i;
        ram_addr_o  = head_row;
        ram_wdata_o = rmw_wdata;
        fifo_pop    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = FLUSH;
    endcase
    if (flush_bp_i) begin
      state_d     = FLUSH;
      flush_row_d = '0;
    end
    if (!rst_ni) begin
      pred_gnt_o  = 1'b0;
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= FLUSH;
      flush_row_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_row_q <= flush_row_d;
    end
  end

  assign busy_o     = (state_q == FLUSH);
  assign upd_full_o = fifo_full;

`ifdef BHT_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_bp_i) drop_cnt_d = '0;
    else if (upd_accept && fifo_full && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign upd_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed self-checking bench for bht_update_sched (128 entries, 2 per fetch,
// 64 rows, FIFO depth 4) with a behavioural 1-cycle-latency RAM.
module tb_bht_update_sched;

  logic                           clk;
  logic                           rst_n;
  logic                           flush_bp;
  logic                           debug_mode;
  logic                           pred_req;
  logic [5:0]                     pred_row;
  logic                           pred_gnt;
  bht_pkg::bht_update_default_t   upd;
  logic                           upd_full;
  logic                           busy;
  logic                           ram_req;
  logic                           ram_we;
  logic [5:0]                     ram_addr;
  logic [3:0]                     ram_wdata;
  logic [3:0]                     ram_rdata;
`ifdef BHT_SCHED_STATS_EN
  logic [15:0]                    drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [64];
  logic [9:0] wr_q [$];
  bit         mon_en;
  int         gnt_cnt;

  bht_update_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_bp_i   (flush_bp),
    .debug_mode_i (debug_mode),
    .pred_req_i   (pred_req),
    .pred_row_i   (pred_row),
    .pred_gnt_o   (pred_gnt),
    .bht_update_i (upd),
    .upd_full_o   (upd_full),
    .busy_o       (busy),
    .ram_req_o    (ram_req),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
`ifdef BHT_SCHED_STATS_EN
    ,
    .upd_drop_cnt_o (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Log RAM writes and grants mid-cycle, well away from the clock edges
  always begin
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      if (ram_req && ram_we) wr_q.push_back({ram_addr, ram_wdata});
      if (pred_gnt) gnt_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_upd(input logic [6:0] idx, input logic taken);
    upd                = '0;
    upd.valid          = 1'b1;
    upd.pc             = 32'h8000_0000 | {23'd0, idx, 2'b00};
    upd.taken          = taken;
    upd.metadata.index = idx;
  endtask

  task automatic clr_upd();
    upd = '0;
  endtask

  // Called at the negedge where flush row 0 is being written.
  task automatic flush_walk(input string tag);
    logic [12:0] e;
    for (int i = 0; i < 64; i++) begin
      #1;
      e = {3'b111, 6'(i), 4'b0101};
      chk($sformatf("%s_row%0d", tag, i), {busy, ram_req, ram_we, ram_addr, ram_wdata}, e);
      @(negedge clk);
    end
    #1;
    chk({tag, "_idle"}, {busy, ram_req}, 2'b00);
  endtask

  task automatic chk_wr(input string tag, input int n, input logic [9:0] exp);
    logic [9:0] obs;
    obs = (n < wr_q.size()) ? wr_q[n] : 10'h3FF;
    chk($sformatf("%s_wr%0d", tag, n), obs, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush_bp   = 1'b0;
    debug_mode = 1'b0;
    pred_req   = 1'b0;
    pred_row   = '0;
    upd        = '0;
    mon_en     = 1'b0;
    gnt_cnt    = 0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ram", {ram_req, ram_we, ram_addr, ram_wdata}, 0);
    chk("rst_gnt_full", {pred_gnt, upd_full}, 0);
`ifdef BHT_SCHED_STATS_EN
    chk("rst_drop", drop_cnt, 0);
`endif

    // Initial flush walk: 64 cycles, rows 0..63 with 2'b01 per column
    @(negedge clk);
    rst_n = 1'b1;
    flush_walk("init");

    // Single taken update, index 5 -> row 2, column 1 becomes 2'b10
    @(negedge clk); drive_upd(7'd5, 1'b1); #1;
    chk("u1_c0", {ram_req, pred_gnt}, 0);
    @(negedge clk); clr_upd(); #1;
    chk("u1_c1", ram_req, 0);
    @(negedge clk); #1;
    chk("u1_rd", {ram_req, ram_we, ram_addr, pred_gnt}, {1'b1, 1'b0, 6'd2, 1'b0});
    @(negedge clk); #1;
    chk("u1_wr", {ram_req, ram_we, ram_addr, ram_wdata, pred_gnt}, {1'b1, 1'b1, 6'd2, 4'b1001, 1'b0});
    @(negedge clk); #1;
    chk("u1_done", ram_req, 0);

    // Four taken updates to index 4 (row 2 col 0): 10, 11, 11, 11
    wr_q.delete(); mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_upd(7'd4, 1'b1);
    end
    @(negedge clk); clr_upd();
    repeat (12) @(negedge clk);
    #1;
    chk("tk_count", wr_q.size(), 4);
    chk_wr("tk", 0, {6'd2, 4'b1010});
    chk_wr("tk", 1, {6'd2, 4'b1011});
    chk_wr("tk", 2, {6'd2, 4'b1011});
    chk_wr("tk", 3, {6'd2, 4'b1011});

    // Four not-taken updates to the same counter: 10, 01, 00, 00
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_upd(7'd4, 1'b0);
    end
    @(negedge clk); clr_upd();
    repeat (12) @(negedge clk);
    #1;
    chk("nt_count", wr_q.size(), 4);
    chk_wr("nt", 0, {6'd2, 4'b1010});
    chk_wr("nt", 1, {6'd2, 4'b1001});
    chk_wr("nt", 2, {6'd2, 4'b1000});
    chk_wr("nt", 3, {6'd2, 4'b1000});

    // 10 cycles of prediction requests starve two queued updates
    wr_q.delete(); gnt_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pred_req = 1'b1;
      pred_row = 6'(i);
      if (i == 0)      drive_upd(7'd6, 1'b1);
      else if (i == 1) drive_upd(7'd7, 1'b0);
      else             clr_upd();
      #1;
      chk($sformatf("pred_gnt%0d", i), {pred_gnt, ram_req, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 6'(i)});
    end
    @(negedge clk); pred_req = 1'b0; clr_upd(); #1;
    chk("pred_grants", gnt_cnt, 10);
    chk("pred_no_wr", wr_q.size(), 0);
    repeat (8) @(negedge clk);
    #1;
    chk("pred_upd_count", wr_q.size(), 2);
    chk_wr("pred", 0, {6'd3, 4'b0110});
    chk_wr("pred", 1, {6'd3, 4'b0010});

    // Six back-to-back updates under prediction: 4 queued, 2 dropped
    wr_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pred_req = 1'b1;
      pred_row = '0;
      drive_upd(7'(8 + 2 * i), 1'b1);
      #1;
      if (i == 3) chk("full_before", upd_full, 0);
      if (i == 4) chk("full_set", upd_full, 1);
    end
    @(negedge clk); clr_upd(); #1;
    chk("full_hold", upd_full, 1);
`ifdef BHT_SCHED_STATS_EN
    chk("drop_cnt2", drop_cnt, 2);
`endif
    @(negedge clk); pred_req = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("full_clear", upd_full, 0);
    chk("full_count", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr("full", i, {6'(4 + i), 4'b0110});

    // Updates under debug mode are ignored
    wr_q.delete();
    @(negedge clk); debug_mode = 1'b1; drive_upd(7'd30, 1'b1);
    @(negedge clk); debug_mode = 1'b0; clr_upd();
    repeat (5) @(negedge clk);
    #1;
    chk("dbg_ignored", wr_q.size(), 0);
    mon_en = 1'b0;

    // Flush during UPD_RD: no RMW write, walk restarts at row 0, FIFO cleared
    @(negedge clk); drive_upd(7'd20, 1'b1);
    @(negedge clk); clr_upd();
    @(negedge clk); flush_bp = 1'b1; drive_upd(7'd22, 1'b1); #1;
    chk("fl_rd", {ram_req, ram_we, ram_addr}, {1'b1, 1'b0, 6'd10});
    @(negedge clk); flush_bp = 1'b0; clr_upd();
    flush_walk("fl");
    wr_q.delete(); mon_en = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("fl_fifo_empty", wr_q.size(), 0);
    chk("fl_full", upd_full, 0);
`ifdef BHT_SCHED_STATS_EN
    chk("fl_drop", drop_cnt, 0);
`endif
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
